regfile_param: RTL
==================

REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (power of two, 2..64).
REQ-003 SHALL have parameter NREAD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 31, hard-zero register index; value DEPTH disables the zero register.
REQ-005 SHALL have parameter BYPASS, default 1, where 1 enables write-to-read forwarding.
REQ-006 SHALL have the following ports, with AW = log2(DEPTH):
- Clk  input  1  clock; all state changes on falling edge
- ResetL  input  1  asynchronous active-low reset
- RA  input  NREAD*AW  read addresses; port i = RA[i*AW +: AW]
- BusR  output  NREAD*WIDTH  read data; port i = BusR[i*WIDTH +: WIDTH]
- BusyR  output  NREAD  scoreboard busy flag per read port
- RW  input  AW  write address
- BusW  input  WIDTH  write data
- RegWr  input  1  write enable
- IssueEn  input  1  mark register IssueReg busy
- IssueReg  input  AW  register receiving a pending producer
- AnyBusy  output  1  OR of all busy bits

Function
REQ-007 SHALL commit BusW into register RW on the falling edge of Clk when RegWr=1 and RW!=ZERO_REG.
REQ-008 SHALL ignore writes to ZERO_REG; reading ZERO_REG SHALL return 0 regardless of write history.
REQ-009 SHALL drive each BusR port combinationally from the addressed register, with zero cycles of latency.
REQ-010 SHALL, when BYPASS=1, RegWr=1, RW==RA[i] and RW!=ZERO_REG, drive BusW on BusR port i before the commit edge.
REQ-011 SHALL, when BYPASS=0, show the old value on BusR until the falling edge and the new value after it.
REQ-012 SHALL keep one busy bit per register.
REQ-013 SHALL set the busy bit for IssueReg on the falling edge when IssueEn=1.
REQ-014 SHALL clear the busy bit for RW on the falling edge when RegWr=1.
REQ-015 SHALL leave the busy bit set on a simultaneous IssueEn and RegWr to the same register, because the newest producer wins.
REQ-016 SHALL never set the busy bit for ZERO_REG; IssueEn to ZERO_REG SHALL be a no-op.
REQ-017 SHALL drive BusyR[i] combinationally from the busy bit of RA[i].
REQ-018 SHALL, when BYPASS=1 and the same-register write condition of REQ-010 holds, drive BusyR[i]=0 unless IssueEn targets that same register.
REQ-019 SHALL let all read ports address the same register simultaneously and return identical data on each.
REQ-020 SHALL drive RA or RW values that are at least DEPTH (non-power-of-two misuse) as reads of 0, and SHALL ignore such writes.

Reset
REQ-021 SHALL clear all registers and busy bits to 0 immediately when ResetL=0, independent of Clk.
REQ-022 SHALL hold BusR=0, BusyR=0 and AnyBusy=0 while ResetL=0 (BusR=0 includes any bypassed value).
REQ-023 SHALL drop a write or issue coincident with reset assertion.
REQ-024 SHALL accept the first write or issue on the first falling edge after ResetL deasserts.

Structure
REQ-025 SHALL have a shared package regfile_pkg holding the default WIDTH, DEPTH and ZERO_REG constants, a clog2 address-width function, and the XZR index constant 31.
REQ-026 SHALL implement the busy-bit array and its set/clear logic in the sub-module regfile_scoreboard (DEPTH, ZERO_REG parameters).
REQ-027 SHALL generate the read ports with a generate loop over NREAD; no per-port hand duplication.

Verification
REQ-028 Zero-register test: reset, write 64'h12345678 to reg 31 -> BusR on reg 31 reads 0 before and after the falling edge.
REQ-029 Fill-and-read test: write reg n = n for n=0..30, then read RA pairs (2,3), (10,11) -> BusR = 2,3 then 10,11 on all NREAD ports.
REQ-030 Bypass test (BYPASS=1): RA0=13, RW=13, BusW=64'hABCD, RegWr=1 -> BusR0=64'hABCD within 4 ns, before the edge; with BYPASS=0 -> 13 before the edge, 64'hABCD after.
REQ-031 Scoreboard test: IssueEn to reg 5 -> BusyR=1 after the edge; then RegWr to 5 with IssueEn to 5 in the same cycle -> busy stays 1; RegWr to 5 alone -> BusyR=0, AnyBusy=0.
REQ-032 Mid-operation reset test: assert ResetL=0 between edges after filling -> all BusR=0 and AnyBusy=0 immediately; after release, reg 4 reads 0.
REQ-033 Parameter sweep test: rerun REQ-028 through REQ-032 for WIDTH=32, DEPTH=16, NREAD=4, ZERO_REG=16 (disabled zero register) -> reg 15 is writable.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the parameterised register file
package regfile_pkg;

  localparam int DEFAULT_WIDTH    = 64;
  localparam int DEFAULT_DEPTH    = 32;
  localparam int DEFAULT_NREAD    = 2;
  localparam int DEFAULT_ZERO_REG = 31;
  localparam int XZR              = 31;

  // Address width needed to index a register count; never narrower than one bit.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending-producer busy bits
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ZERO_REG = DEFAULT_ZERO_REG,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [AW-1:0]    set_idx,
  input  logic             clr_en,
  input  logic [AW-1:0]    clr_idx,
  output logic [DEPTH-1:0] busy
);

  logic [DEPTH-1:0] busy_next;

  // A retiring write clears its entry, a new producer sets it; the newest producer wins a tie.
  always_comb begin
    busy_next = busy;
    for (int r = 0; r < DEPTH; r++) begin
      if (clr_en && clr_idx == AW'(r)) busy_next[r] = 1'b0;
      if (set_en && set_idx == AW'(r) && r != ZERO_REG) busy_next[r] = 1'b1;
    end
  end

  // Busy bits advance on the falling edge and clear at once on reset.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

endmodule

// File: rtl/regfile_param.sv
// rtl/regfile_param.sv - multi-read-port register file with zero register, forwarding and scoreboard
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int NREAD    = DEFAULT_NREAD,
  parameter int ZERO_REG = DEFAULT_ZERO_REG,
  parameter int BYPASS   = 1,
  localparam int AW      = clog2(DEPTH)
) (
  input  logic                   Clk,
  input  logic                   ResetL,
  input  logic [NREAD*AW-1:0]    RA,
  output logic [NREAD*WIDTH-1:0] BusR,
  output logic [NREAD-1:0]       BusyR,
  input  logic [AW-1:0]          RW,
  input  logic [WIDTH-1:0]       BusW,
  input  logic                   RegWr,
  input  logic                   IssueEn,
  input  logic [AW-1:0]          IssueReg,
  output logic                   AnyBusy
);

  // One extra bit so that ZERO_REG == DEPTH (zero register disabled) never matches a real index.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] ZERO_W  = (AW+1)'(ZERO_REG);

  // An address that names real, writable storage (in range and not the hard-zero register).
  function automatic logic addr_live(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W) && ({1'b0, a} != ZERO_W);
  endfunction

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             wr_live;

  assign wr_live = RegWr && addr_live(RW);

  // Write port commits on the falling edge; the zero register is never written so it stays 0.
  always_ff @(negedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else if (wr_live) begin
      regs[RW] <= BusW;
    end
  end

  regfile_scoreboard #(
    .DEPTH    (DEPTH),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk     (Clk),
    .rst_n   (ResetL),
    .set_en  (IssueEn),
    .set_idx (IssueReg),
    .clr_en  (RegWr),
    .clr_idx (RW),
    .busy    (busy)
  );

  assign AnyBusy = ResetL && (|busy);

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] ra;
    logic          fwd;
    logic          issue_same;

    assign ra         = RA[g*AW +: AW];
    assign fwd        = (BYPASS != 0) && wr_live && (RW == ra);
    assign issue_same = IssueEn && (IssueReg == ra);

    // Forwarded data is suppressed during reset just like stored data.
    assign BusR[g*WIDTH +: WIDTH] = (!ResetL || !addr_live(ra)) ? '0 :
                                    fwd                         ? BusW : regs[ra];

    // A forwarded producer is already resolved unless a new producer is issued to the same register.
    assign BusyR[g] = ResetL && ({1'b0, ra} < DEPTH_W) && busy[ra] && !(fwd && !issue_same);
  end

endmodule
